// File: rtl/nearest_neighbor_zoom_nx.sv
// Nearest-neighbour integer upscaler: buffers one input line, then replays it F times with each
// pixel repeated F times. Optional macro NNZ_PIXEL_COUNT_EN adds a 32-bit output pixel counter.
module nearest_neighbor_zoom_nx #(
    parameter int unsigned PIXEL_W    = 8,
    parameter int unsigned MAX_WIDTH  = 320,
    parameter int unsigned MAX_HEIGHT = 240,
    parameter int unsigned MAX_FACTOR = 4,
    localparam int unsigned FW = $clog2(MAX_FACTOR + 1),
    localparam int unsigned WW = $clog2(MAX_WIDTH + 1),
    localparam int unsigned HW = $clog2(MAX_HEIGHT + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WW-1:0]      img_width,
    input  logic [HW-1:0]      img_height,
    input  logic [FW-1:0]      zoom_factor,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
`ifdef NNZ_PIXEL_COUNT_EN
    ,
    output logic [31:0]        out_count
`endif
);

    localparam int unsigned AW = $clog2(MAX_WIDTH);
    localparam logic [FW-1:0] MaxF = FW'(MAX_FACTOR);
    localparam logic [WW-1:0] MaxW = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] MaxH = HW'(MAX_HEIGHT);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [WW-1:0]     r_width;
    logic [HW-1:0]     r_height;
    logic [FW-1:0]     r_factor;
    logic [WW-1:0]     r_col;
    logic [HW-1:0]     r_row;
    logic [FW-1:0]     r_h_rep;
    logic [FW-1:0]     r_v_rep;
    logic              r_cfg_err;
    logic [PIXEL_W-1:0] r_buf [MAX_WIDTH];

    logic w_cfg_ok, w_accept, w_in_xfer, w_out_xfer;
    logic w_h_end, w_c_end, w_v_end, w_r_end;

    assign w_cfg_ok = (zoom_factor != '0) && (zoom_factor <= MaxF) &&
                      (img_width != '0) && (img_width <= MaxW) &&
                      (img_height != '0) && (img_height <= MaxH);
    assign w_accept   = (r_state == StIdle) && start && w_cfg_ok;
    assign w_in_xfer  = (r_state == StLoad) && in_valid;
    assign w_out_xfer = (r_state == StEmit) && out_ready;
    assign w_h_end    = (r_h_rep == r_factor - FW'(1));
    assign w_c_end    = (r_col == r_width - WW'(1));
    assign w_v_end    = (r_v_rep == r_factor - FW'(1));
    assign w_r_end    = (r_row == r_height - HW'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: if (w_accept) w_state_nxt = StLoad;
            StLoad: if (w_in_xfer && w_c_end) w_state_nxt = StEmit;
            StEmit: begin
                if (w_out_xfer && w_h_end && w_c_end && w_v_end) begin
                    w_state_nxt = w_r_end ? StDone : StLoad;
                end
            end
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Outputs decode straight from state so the async reset zeroes them immediately.
    assign in_ready  = (r_state == StLoad);
    assign out_valid = (r_state == StEmit);
    assign out_pixel = out_valid ? r_buf[r_col[AW-1:0]] : '0;
    assign out_last  = out_valid && w_h_end && w_c_end;
    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone);
    assign cfg_err   = r_cfg_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_width   <= '0;
            r_height  <= '0;
            r_factor  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_h_rep   <= '0;
            r_v_rep   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_width  <= img_width;
                        r_height <= img_height;
                        r_factor <= zoom_factor;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_h_rep  <= '0;
                        r_v_rep  <= '0;
                    end else if (start) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                StLoad: begin
                    if (w_in_xfer) r_col <= w_c_end ? '0 : r_col + WW'(1);
                end
                StEmit: begin
                    // h_rep innermost, then col, then v_rep; row advances once per input line.
                    if (w_out_xfer) begin
                        if (!w_h_end) begin
                            r_h_rep <= r_h_rep + FW'(1);
                        end else begin
                            r_h_rep <= '0;
                            if (!w_c_end) begin
                                r_col <= r_col + WW'(1);
                            end else begin
                                r_col <= '0;
                                if (!w_v_end) begin
                                    r_v_rep <= r_v_rep + FW'(1);
                                end else begin
                                    r_v_rep <= '0;
                                    if (!w_r_end) r_row <= r_row + HW'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) r_buf[r_col[AW-1:0]] <= in_pixel;
    end

`ifdef NNZ_PIXEL_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_count <= '0;
        end else if (w_accept) begin
            out_count <= '0;
        end else if (w_out_xfer) begin
            out_count <= out_count + 32'd1;
        end
    end
`endif

endmodule
